imem_loader: RTL

Boot-time program loader for the instruction memory. It accepts a byte stream on a valid/ready port, assembles little-endian 32-bit instruction words and drives the imem write port with word-aligned byte addresses. It holds the pipeline stalled (`core_stall`) until the whole image is written, then releases the core. It sits between an external byte source (UART/debug bridge) and the imem write port, alongside the core's fetch read port.

---
 rtl/imem_loader.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the instruction memory. It takes a byte stream
// on a valid/ready port and assembles little-endian 32-bit words from it. Each
// word is written to the imem write port at a word-aligned byte address. The
// core is held stalled until the whole image has been written.
//
// Stream format: N (low byte first), then 4*N data bytes. When the optional
// trailer is enabled, one XOR checksum byte follows the data.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a CHK state and an 8-bit XOR checksum register are built in.
//   The loader then expects one trailer byte after the data. A mismatch sends
//   the loader to the error state.
//
// Parameters:
//   DEPTH  imem capacity in 32-bit words
//   CNT_W  width of the word-count header field
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_in_valid     byte source has data
//   i_in_data      stream byte
//   o_in_ready     loader accepts a byte this cycle
//   i_reload       single-cycle pulse; restarts loading from DONE
//   o_imem_we      imem write enable, one-cycle pulse per word
//   o_imem_wa      imem byte address (word aligned)
//   o_imem_wd      imem write data
//   o_core_stall   holds fetch stage and PC
//   o_load_done    image loaded, core running
//   o_error        load failed; sticky until reset
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    input  logic        i_reload,
    output logic        o_imem_we,
    output logic [31:0] o_imem_wa,
    output logic [31:0] o_imem_wd,
    output logic        o_core_stall,
    output logic        o_load_done,
    output logic        o_error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [7:0]         r_n_lo;
    logic [CNT_W-1:0]   r_n;
    logic [IDX_W-1:0]   r_word_idx;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_asm;        // first three bytes of the word, byte 0 in [7:0]
    logic               r_imem_we;
    logic [31:0]        r_imem_wa;
    logic [31:0]        r_imem_wd;
    logic               r_core_stall;
    logic               r_load_done;
    logic               r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         r_chk;
`endif

    logic               w_in_ready;
    logic               w_accept;
    logic [15:0]        w_hdr_n;
    logic               w_last_word;
    logic               w_word_done;

    // Ready depends only on state, so there is no combinational path from valid.
    assign w_in_ready  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                         (r_state == S_CHK) ||
`endif
                         (r_state == S_DATA);
    assign w_accept    = i_in_valid & w_in_ready;
    assign w_hdr_n     = {i_in_data, r_n_lo};
    assign w_last_word = ((32'(r_word_idx) + 32'd1) == 32'(r_n));
    assign w_word_done = (r_state == S_DATA) && w_accept && (r_byte_cnt == 2'd3);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LEN_LO: begin
                if (w_accept) w_next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if (32'(w_hdr_n) > 32'(DEPTH)) begin
                        w_next_state = S_ERR;
                    end else if (w_hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        // An empty image still carries its (zero) trailer.
                        w_next_state = S_CHK;
`else
                        w_next_state = S_DONE;
`endif
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_done && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next_state = S_CHK;
`else
                    w_next_state = S_FLUSH;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) w_next_state = (i_in_data == r_chk) ? S_FLUSH : S_ERR;
            end
`endif
            // Gives the last imem write its cycle before the stall is released.
            S_FLUSH: w_next_state = S_DONE;
            S_DONE: begin
                if (i_reload) w_next_state = S_LEN_LO;
            end
            S_ERR:   w_next_state = S_ERR;
            default: w_next_state = S_LEN_LO;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_LEN_LO;
            r_n_lo       <= '0;
            r_n          <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_imem_we    <= 1'b0;
            r_imem_wa    <= '0;
            r_imem_wd    <= '0;
            r_core_stall <= 1'b1;
            r_load_done  <= 1'b0;
            r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk        <= '0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_imem_we <= 1'b0;

            // Status outputs are registered from the state being entered, so
            // they change on the same edge as the state does.
            r_core_stall <= (w_next_state != S_DONE);
            r_load_done  <= (w_next_state == S_DONE);
            r_error      <= (w_next_state == S_ERR);

            case (r_state)
                S_LEN_LO: begin
                    if (w_accept) r_n_lo <= i_in_data;
                end
                S_LEN_HI: begin
                    if (w_accept) r_n <= CNT_W'(w_hdr_n);
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk <= r_chk ^ i_in_data;
`endif
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_imem_we <= 1'b1;
                            r_imem_wa <= 32'({r_word_idx, 2'b00});
                            r_imem_wd <= {i_in_data, r_asm};
                            // Hold the index on the final word so it never wraps.
                            if (!w_last_word) r_word_idx <= r_word_idx + 1'b1;
                        end else begin
                            r_asm <= {i_in_data, r_asm[23:8]};
                        end
                    end
                end
                S_DONE: begin
                    if (i_reload) begin
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk      <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_wa    = r_imem_wa;
    assign o_imem_wd    = r_imem_wd;
    assign o_core_stall = r_core_stall;
    assign o_load_done  = r_load_done;
    assign o_error      = r_error;

endmodule
